demux_stream_buffer: RTL and testbench

- Registered 1-to-2 stream demultiplexer.
- Each input word carries its own select bit and is steered into one of two per-output FIFOs.
- Each FIFO presents a valid/ready stream to its consumer.
- Sits directly downstream of the combinational 1:2 demux stage. It turns the unbuffered out1/out2 split into back-pressured, independently drained channels for the register-bank and ALU-operand paths.

---
 rtl/demux_pkg.sv | 8 +
 rtl/demux_buf_fifo.sv | 62 ++++++
 rtl/demux_stream_buffer.sv | 89 ++++++++
 tb/tb_demux_stream_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared channel encodings and counter type for the demux stream buffer.
// No logic; types and constants only.
package demux_pkg;
    localparam logic DEMUX_CH1 = 1'b0;
    localparam logic DEMUX_CH2 = 1'b1;

    typedef logic [7:0] cnt_t;
endpackage

// File: rtl/demux_buf_fifo.sv
// Single-channel DEPTH-entry FIFO with head-of-queue data always presented.
// Latency: a pushed word is at the head one cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module demux_buf_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demux_stream_buffer.sv
// Registered 1:2 stream demux; each word steered by in_sel into a per-channel FIFO.
// Latency: 1 cycle from push edge to outN_valid. Optional pop counters: DEMUX_BUF_CNT_EN.
// Backpressure: in_ready = !full of the selected channel, independent of outN_ready.
module demux_stream_buffer
    import demux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_BUF_CNT_EN
    ,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2
`endif
);
    logic             push1, push2;
    logic             pop1, pop2;
    logic             empty1, empty2;
    logic             full1, full2;
    logic [WIDTH-1:0] head1, head2;

    assign in_ready = (in_sel == DEMUX_CH2) ? !full2 : !full1;
    assign push1    = in_valid && in_ready && (in_sel == DEMUX_CH1);
    assign push2    = in_valid && in_ready && (in_sel == DEMUX_CH2);
    assign pop1     = !empty1 && out1_ready;
    assign pop2     = !empty2 && out2_ready;

    // An empty channel drives zero, matching the idle leg of the upstream demux.
    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign out1_data  = empty1 ? '0 : head1;
    assign out2_data  = empty2 ? '0 : head2;

    demux_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .head_data (head1),
        .empty     (empty1),
        .full      (full1)
    );

    demux_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push2),
        .push_data (in_data),
        .pop       (pop2),
        .head_data (head2),
        .empty     (empty2),
        .full      (full2)
    );

`ifdef DEMUX_BUF_CNT_EN
    cnt_t cnt1_q;
    cnt_t cnt2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            if (pop1) begin
                cnt1_q <= cnt1_q + 8'd1;
            end
            if (pop2) begin
                cnt2_q <= cnt2_q + 8'd1;
            end
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif
endmodule

// File: tb/tb_demux_stream_buffer.sv
// Directed bench for demux_stream_buffer: steering, back-pressure, wrap, reset, counters.
module tb_demux_stream_buffer;
    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
`ifdef DEMUX_BUF_CNT_EN
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux_stream_buffer #(.WIDTH(16), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
`ifdef DEMUX_BUF_CNT_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 16'hFFFF;
        in_sel     = 1'b0;
        in_valid   = 1'b1;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with in_valid high.
        step();
        step();
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out2_valid", 32'(out2_valid), 32'd0);
        chk("rst_out1_data", 32'(out1_data), 32'd0);
        chk("rst_out2_data", 32'(out2_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_BUF_CNT_EN
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        chk("rst_no_push", 32'(out1_valid), 32'd0);

        // Steering.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hA5A5;
        step();
        chk("steer_o1_valid", 32'(out1_valid), 32'd1);
        chk("steer_o1_data", 32'(out1_data), 32'hA5A5);
        chk("steer_o2_idle_valid", 32'(out2_valid), 32'd0);
        chk("steer_o2_idle_data", 32'(out2_data), 32'd0);
        in_sel = 1'b1; in_data = 16'h5A5A;
        step();
        in_valid = 1'b0;
        chk("steer_o1_data2", 32'(out1_data), 32'hA5A5);
        chk("steer_o2_data", 32'(out2_data), 32'h5A5A);
        chk("steer_o2_valid", 32'(out2_valid), 32'd1);
        out1_ready = 1'b1; out2_ready = 1'b1;
        step();
        out1_ready = 1'b0; out2_ready = 1'b0;
        chk("steer_drained1", 32'(out1_valid), 32'd0);
        chk("steer_drained2", 32'(out2_valid), 32'd0);

        // Full / back-pressure on channel 1.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'd1;
        step();
        in_data = 16'd2;
        step();
        in_data = 16'd3;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_held_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out1_data), 32'd1);
        in_sel = 1'b1; in_data = 16'h0077;
        #1;
        chk("full_other_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("full_o2_valid", 32'(out2_valid), 32'd1);
        chk("full_o2_data", 32'(out2_data), 32'h0077);
        out1_ready = 1'b1; out2_ready = 1'b1;
        step();
        chk("full_pop1", 32'(out1_data), 32'd2);
        chk("full_o2_empty", 32'(out2_valid), 32'd0);
        step();
        chk("full_empty1", 32'(out1_valid), 32'd0);
        in_sel = 1'b0;
        #1;
        chk("full_ready_again", 32'(in_ready), 32'd1);

        // Streaming drain with pointer wrap.
        out1_ready = 1'b1; out2_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(i);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            step();
            chk("stream_data", 32'(out1_data), 32'(i));
            chk("stream_valid", 32'(out1_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_done", 32'(out1_valid), 32'd0);

        // Simultaneous push and pop on channel 1.
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111;
        step();
        in_data = 16'h2222; out1_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("simul_head", 32'(out1_data), 32'h2222);
        chk("simul_valid", 32'(out1_valid), 32'd1);
        step();
        out1_ready = 1'b0;
        chk("simul_count_one", 32'(out1_valid), 32'd0);

        // Mid-stream reset.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h4444;
        step();
        in_sel = 1'b1; in_data = 16'h3333;
        step();
        chk("mid_pre_o1", 32'(out1_valid), 32'd1);
        chk("mid_pre_o2", 32'(out2_valid), 32'd1);
        rst_n = 1'b0; in_data = 16'h9999;
        step();
        chk("mid_rst_o1_valid", 32'(out1_valid), 32'd0);
        chk("mid_rst_o2_valid", 32'(out2_valid), 32'd0);
        chk("mid_rst_o1_data", 32'(out1_data), 32'd0);
        chk("mid_rst_o2_data", 32'(out2_data), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("mid_post_o2", 32'(out2_valid), 32'd0);

`ifdef DEMUX_BUF_CNT_EN
        // 257 pops on channel 2 wrap its counter to 1.
        out2_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 16'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cnt2_wrap", 32'(cnt2), 32'd1);
        chk("cnt1_idle", 32'(cnt1), 32'd0);
        out2_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
